// File: rtl/fp_wb_pkg.sv
// FP writeback shared definitions.
// Widths, register count and the FP-space index helper.
package fp_wb_pkg;

    localparam int FP_ADDR_W  = 6;
    localparam int FP_DATA_W  = 32;
    localparam int FP_NREGS   = 32;
    localparam int FP_VLD_BIT = 5;

    function automatic logic [4:0] fp_idx(
        input logic [FP_ADDR_W-1:0] addr
    );
        return addr[4:0];
    endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// FP pending-destination scoreboard: set on issue, clear on commit,
// RAW/WAW stall with commit bypass, sticky error on unexpected commit.
// Ports: clk, reset (async low), issue_* (in), wb_we/wb_dest (in),
//        issue_stall, pending, wb_err (out).
module fp_scoreboard
    import fp_wb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [FP_ADDR_W-1:0] issue_dest,
    input  logic [FP_ADDR_W-1:0] issue_src1,
    input  logic [FP_ADDR_W-1:0] issue_src2,
    input  logic                 wb_we,
    input  logic [FP_ADDR_W-1:0] wb_dest,
    output logic                 issue_stall,
    output logic [FP_NREGS-1:0]  pending,
    output logic                 wb_err
);

    logic                byp;
    logic [4:0]          byp_idx;
    logic                haz_s1;
    logic                haz_s2;
    logic                haz_d;
    logic                set_v;
    logic [FP_NREGS-1:0] pend_nxt;

    assign byp     = wb_we & wb_dest[FP_VLD_BIT];
    assign byp_idx = fp_idx(wb_dest);

    // A register being committed this cycle is served by the regfile
    // bypass, so it no longer counts as a hazard.
    function automatic logic hazard(
        input logic [FP_ADDR_W-1:0] r,
        input logic [FP_NREGS-1:0]  pend,
        input logic                 bv,
        input logic [4:0]           bi
    );
        return r[FP_VLD_BIT] & pend[fp_idx(r)] & ~(bv & (bi == fp_idx(r)));
    endfunction

    always_comb begin
        haz_s1      = hazard(issue_src1, pending, byp, byp_idx);
        haz_s2      = hazard(issue_src2, pending, byp, byp_idx);
        haz_d       = hazard(issue_dest, pending, byp, byp_idx);
        issue_stall = issue_valid & (haz_s1 | haz_s2 | haz_d);
    end

    assign set_v = issue_valid & ~issue_stall & issue_dest[FP_VLD_BIT];

    // Clear first, then set: a new producer overrides the retiring one.
    always_comb begin
        pend_nxt = pending;
        if (byp) begin
            pend_nxt[byp_idx] = 1'b0;
        end
        if (set_v) begin
            pend_nxt[fp_idx(issue_dest)] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            wb_err  <= 1'b0;
        end else begin
            pending <= pend_nxt;
            if (byp & ~pending[byp_idx]) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP regfile writeback arbiter: round-robin between FPU result and load
// data, one-cycle registered write port, pending scoreboard for issue.
// Ports: clk, reset (async low), issue_*, alu_*, ld_*, Fp_* write port,
//        pending_po, wb_err_po.
module fp_wb_arbiter
    import fp_wb_pkg::*;
#(
    parameter int DATA_W      = FP_DATA_W,
    parameter int ADDR_W      = FP_ADDR_W,
    parameter int debug_param = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid_pi,
    input  logic [ADDR_W-1:0] issue_dest_pi,
    input  logic [ADDR_W-1:0] issue_src1_pi,
    input  logic [ADDR_W-1:0] issue_src2_pi,
    output logic              issue_stall_po,
    input  logic              alu_valid_pi,
    input  logic [ADDR_W-1:0] alu_dest_pi,
    input  logic [DATA_W-1:0] alu_data_pi,
    output logic              alu_ready_po,
    input  logic              ld_valid_pi,
    input  logic [ADDR_W-1:0] ld_dest_pi,
    input  logic [DATA_W-1:0] ld_data_pi,
    output logic              ld_ready_po,
    output logic              Fp_we_po,
    output logic [ADDR_W-1:0] Fp_destReg_po,
    output logic [DATA_W-1:0] Fp_writeData_po,
    output logic [31:0]       pending_po,
    output logic              wb_err_po
);

    logic              prefer_ld;
    logic              gnt0;
    logic              gnt1;
    logic              xfer;
    logic [ADDR_W-1:0] sel_dest;
    logic [DATA_W-1:0] sel_data;

    // prefer_ld is set after an alu grant so the load side wins the next
    // contended cycle. Grants are held off while reset is asserted.
    assign gnt0 = reset & alu_valid_pi & (~ld_valid_pi | ~prefer_ld);
    assign gnt1 = reset & ld_valid_pi & (~alu_valid_pi | prefer_ld);
    assign xfer = gnt0 | gnt1;

    assign alu_ready_po = gnt0;
    assign ld_ready_po  = gnt1;

    assign sel_dest = gnt0 ? alu_dest_pi : ld_dest_pi;
    assign sel_data = gnt0 ? alu_data_pi : ld_data_pi;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prefer_ld       <= 1'b0;
            Fp_we_po        <= 1'b0;
            Fp_destReg_po   <= '0;
            Fp_writeData_po <= '0;
        end else begin
            Fp_we_po <= xfer & sel_dest[FP_VLD_BIT];
            if (xfer) begin
                prefer_ld <= gnt0;
            end
            // Non-FP destinations are accepted but never reach the port.
            if (xfer & sel_dest[FP_VLD_BIT]) begin
                Fp_destReg_po   <= sel_dest;
                Fp_writeData_po <= sel_data;
            end
        end
    end

    fp_scoreboard u_sb (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid_pi),
        .issue_dest  (issue_dest_pi),
        .issue_src1  (issue_src1_pi),
        .issue_src2  (issue_src2_pi),
        .wb_we       (Fp_we_po),
        .wb_dest     (Fp_destReg_po),
        .issue_stall (issue_stall_po),
        .pending     (pending_po),
        .wb_err      (wb_err_po)
    );

    // Committed-write counter, visible in waveforms when debugging.
    generate
        if (debug_param != 0) begin : g_dbg
            logic [31:0] commit_cnt;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    commit_cnt <= '0;
                end else if (Fp_we_po) begin
                    commit_cnt <= commit_cnt + 32'd1;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Randomized and directed bench for fp_wb_arbiter against a
// behavioural model of arbitration, write port and scoreboard.
module tb_fp_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [5:0]  issue_dest, issue_src1, issue_src2;
    logic        issue_stall;
    logic        alu_valid;
    logic [5:0]  alu_dest;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [5:0]  ld_dest;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        fp_we;
    logic [5:0]  fp_dest;
    logic [31:0] fp_data;
    logic [31:0] pending;
    logic        wb_err;

    int total = 0;
    int bad   = 0;

    // model state
    bit [31:0] m_pend;
    bit        m_err;
    bit        m_last_ld;
    bit        m_we;
    bit [5:0]  m_dest;
    bit [31:0] m_data;
    bit        g0, g1;

    always #5 clk = ~clk;

    fp_wb_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .issue_valid_pi  (issue_valid),
        .issue_dest_pi   (issue_dest),
        .issue_src1_pi   (issue_src1),
        .issue_src2_pi   (issue_src2),
        .issue_stall_po  (issue_stall),
        .alu_valid_pi    (alu_valid),
        .alu_dest_pi     (alu_dest),
        .alu_data_pi     (alu_data),
        .alu_ready_po    (alu_ready),
        .ld_valid_pi     (ld_valid),
        .ld_dest_pi      (ld_dest),
        .ld_data_pi      (ld_data),
        .ld_ready_po     (ld_ready),
        .Fp_we_po        (fp_we),
        .Fp_destReg_po   (fp_dest),
        .Fp_writeData_po (fp_data),
        .pending_po      (pending),
        .wb_err_po       (wb_err)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit haz(input bit [5:0] r);
        bit bypassed;
        bypassed = m_we && m_dest[5] && (m_dest[4:0] == r[4:0]);
        return r[5] && m_pend[r[4:0]] && !bypassed;
    endfunction

    task automatic model_reset();
        m_pend    = '0;
        m_err     = 1'b0;
        m_last_ld = 1'b1;
        m_we      = 1'b0;
        m_dest    = '0;
        m_data    = '0;
        g0        = 1'b0;
        g1        = 1'b0;
    endtask

    task automatic clear_in();
        issue_valid = 0; issue_dest = 0; issue_src1 = 0; issue_src2 = 0;
        alu_valid = 0; alu_dest = 0; alu_data = 0;
        ld_valid = 0; ld_dest = 0; ld_data = 0;
    endtask

    // Check one cycle at negedge, then advance the model across posedge.
    task automatic step();
        bit        e0, e1, es;
        bit [31:0] np;
        bit [5:0]  cd;
        @(negedge clk);
        if (alu_valid && ld_valid) begin
            e0 = m_last_ld;
            e1 = !m_last_ld;
        end else begin
            e0 = alu_valid;
            e1 = ld_valid;
        end
        es = issue_valid && (haz(issue_src1) || haz(issue_src2) || haz(issue_dest));
        chk("alu_ready", alu_ready, e0);
        chk("ld_ready", ld_ready, e1);
        chk("stall", issue_stall, es);
        chk("we", fp_we, m_we);
        if (m_we) begin
            chk("dest", fp_dest, m_dest);
            chk("data", fp_data, m_data);
        end
        chk("pending", pending, m_pend);
        chk("wb_err", wb_err, m_err);
        np = m_pend;
        if (m_we) begin
            if (!m_pend[m_dest[4:0]]) m_err = 1'b1;
            np[m_dest[4:0]] = 1'b0;
        end
        if (issue_valid && !es && issue_dest[5]) np[issue_dest[4:0]] = 1'b1;
        if (e0 || e1) begin
            m_last_ld = e1;
            cd = e0 ? alu_dest : ld_dest;
            m_we = cd[5];
            if (cd[5]) begin
                m_dest = cd;
                m_data = e0 ? alu_data : ld_data;
            end
        end else begin
            m_we = 1'b0;
        end
        m_pend = np;
        g0 = e0;
        g1 = e1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        clear_in();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we", fp_we, 0);
        chk("rst_dest", fp_dest, 0);
        chk("rst_data", fp_data, 0);
        chk("rst_pend", pending, 0);
        chk("rst_err", wb_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // RAW on a pending register, released by the commit bypass
        issue_valid = 1; issue_dest = 6'h25;
        step();
        issue_dest = 6'h00; issue_src1 = 6'h25;
        step();
        alu_valid = 1; alu_dest = 6'h25; alu_data = 32'h4000_0000;
        step();
        alu_valid = 0;
        step();
        issue_valid = 0; issue_src1 = 0;
        step();
        chk("t3_pend5", pending[5], 0);

        // commit and re-issue of the same register in one cycle
        issue_valid = 1; issue_dest = 6'h27;
        step();
        issue_valid = 0;
        alu_valid = 1; alu_dest = 6'h27; alu_data = 32'h1234_5678;
        step();
        alu_valid = 0;
        issue_valid = 1;
        step();
        issue_valid = 0; issue_dest = 0;
        step();
        chk("t4_pend7", pending[7], 1);

        // dropped non-FP write, then commit to a non-pending register
        ld_valid = 1; ld_dest = 6'h05; ld_data = 32'hDEAD_BEEF;
        step();
        ld_valid = 0;
        step();
        alu_valid = 1; alu_dest = 6'h2A; alu_data = 32'h0BAD_F00D;
        step();
        alu_valid = 0;
        step();
        step();
        chk("t5_err", wb_err, 1);

        // async reset between edges with both requesters pending
        alu_valid = 1; alu_dest = 6'h21; alu_data = 32'h1111_1111;
        ld_valid = 1; ld_dest = 6'h22; ld_data = 32'h2222_2222;
        #2;
        reset = 1'b0;
        #1;
        chk("ar_alu_rdy", alu_ready, 0);
        chk("ar_ld_rdy", ld_ready, 0);
        chk("ar_we", fp_we, 0);
        chk("ar_dest", fp_dest, 0);
        chk("ar_data", fp_data, 0);
        chk("ar_pend", pending, 0);
        chk("ar_err", wb_err, 0);
        chk("ar_stall", issue_stall, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        chk("ar_first_alu", g0, 1);
        alu_valid = 0; ld_valid = 0;

        // single write
        alu_valid = 1; alu_dest = 6'h23; alu_data = 32'h3F80_0000;
        step();
        alu_valid = 0;
        step();

        // contention: grants alternate
        alu_valid = 1; alu_dest = 6'h31; alu_data = 32'hA0;
        ld_valid = 1; ld_dest = 6'h32; ld_data = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (g0) begin alu_dest = alu_dest + 6'd2; alu_data++; end
            if (g1) begin ld_dest = ld_dest + 6'd2; ld_data++; end
        end
        alu_valid = 0; ld_valid = 0;
        step();

        // random traffic; a stalled requester keeps its payload
        for (int n = 0; n < 500; n++) begin
            if (!(alu_valid && !g0)) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_dest = {1'($urandom_range(0, 3) != 0), 2'b00, 3'($urandom)};
                alu_data = $urandom;
            end
            if (!(ld_valid && !g1)) begin
                ld_valid = 1'($urandom_range(0, 1));
                ld_dest = {1'($urandom_range(0, 3) != 0), 2'b00, 3'($urandom)};
                ld_data = $urandom;
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_dest = {1'($urandom_range(0, 1)), 2'b00, 3'($urandom)};
            issue_src1 = {1'($urandom_range(0, 1)), 2'b00, 3'($urandom)};
            issue_src2 = {1'($urandom_range(0, 1)), 2'b00, 3'($urandom)};
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
